tri_bbox_scan: RTL and testbench
================================

// Module: tri_bbox_scan
// PURPOSE
//  Upstream feeder of the point-in-triangle sign test. Accepts one triangle
//  (3 signed vertices), computes its axis-aligned bounding box, then streams
//  every integer point (px,py) of the box in raster order, each paired with
//  the held vertices. The sign-test stage consumes the stream and returns in/out.
// PARAMETERS
//  W      12   coordinate width, two's-complement signed
//  SCR_W  640  screen width in pixels; used only with TRI_CLIP_EN
//  SCR_H  480  screen height in pixels; used only with TRI_CLIP_EN
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    triangle offered
//  in_ready   out  1    high only in IDLE
//  x1..y3     in   W    vertex coords, signed (6 ports: x1,y1,x2,y2,x3,y3)
//  out_valid  out  1    point valid
//  out_ready  in   1    consumer accepts point
//  px, py     out  W    current point, signed
//  tx1..ty3   out  W    registered copy of accepted vertices, stable per triangle
//  out_last   out  1    qualifies the final point of the triangle
//  tri_done   out  1    one-cycle pulse: triangle fully emitted (or empty)
// BEHAVIOUR
//  - Interface: one clock clk; reset rst_n is asynchronous, active-low.
//  - Reset: state=IDLE. out_valid, out_last, tri_done = 0. px, py, tx*, ty* = 0.
//    in_ready is 1 during and after reset. Reset mid-scan aborts the current
//    triangle with no further points emitted and no tri_done pulse.
//  - FSM: IDLE -> BBOX -> SCAN -> IDLE.
//    IDLE: in_valid&&in_ready captures vertices into tx*/ty*.
//    BBOX: one cycle; xmin/xmax/ymin/ymax = signed min/max of the 3 vertices;
//    px=xmin, py=ymin.
//    SCAN: out_valid=1.
//  - Latency: accept in cycle N; first out_valid in N+2.
//  - Stall: while out_valid && !out_ready, px/py/out_last/tx*/ty* hold stable.
//  - Advance on handshake: if px!=xmax then px++. Otherwise px=xmin and py++.
//    Use equality compares only, so no overflow at the range edge (+2047).
//  - out_last = (px==xmax)&&(py==ymax). On the last handshake: state=IDLE,
//    out_valid=0, tri_done=1 in the next cycle, in_ready=1 in that same cycle.
//  - Degenerate triangle (collinear or coincident vertices) is still scanned
//    over its box. A single-point box emits exactly 1 point, with out_last=1.
//  - All min/max and compares are signed W-bit. No arithmetic wider than W.
// CONFIGURATION
//  - TRI_CLIP_EN defined: in BBOX, clamp the box to x in [0,SCR_W-1] and
//    y in [0,SCR_H-1].
//    Box fully off-screen (xmax<0, ymax<0, xmin>SCR_W-1 or ymin>SCR_H-1):
//    no points are emitted; return to IDLE with tri_done=1 in cycle N+2.
//  - TRI_CLIP_EN undefined: no clamping; every triangle emits >= 1 point.
//    SCR_W and SCR_H are ignored.
// STRUCTURE
//  - tri_pkg: parameter W, typedef coord_t (signed [W-1:0]), state enum
//    {IDLE,BBOX,SCAN}.
//  - Sub-module minmax3: combinational signed min/max of 3 coord_t values.
//    Instanced twice (x and y).
// TESTING
//  1. (0,0),(2,0),(0,2): 9 points (0,0),(1,0),(2,0),(0,1)..(2,2);
//     out_last only on (2,2); tri_done 1 cycle after.
//  2. Same triangle, out_ready=0 for 3 cycles at (1,0): px=1, py=0 held;
//     sequence has no skip or duplicate.
//  3. All vertices (5,-3): exactly one point (5,-3) with out_last=1;
//     first out_valid exactly 2 cycles after accept.
//  4. (-2,-1),(1,3),(0,-4): box x -2..1, y -4..3; 32 points;
//     first (-2,-4), last (1,3).
//  5. rst_n low during point 4 of test 1: out_valid=0 immediately, no
//     tri_done, in_ready=1; next triangle starts at its own (xmin,ymin).
//  6. TRI_CLIP_EN: (-5,-5),(-1,-1),(-3,-1) -> 0 points, tri_done at N+2;
//     (630,470),(700,470),(630,500) -> x 630..639, y 470..479, 100 points.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared types for the triangle bounding-box scanner: coordinate width/type and FSM states.
package tri_pkg;

    localparam int unsigned W = 12;

    typedef logic signed [W-1:0] coord_t;

    typedef enum logic [1:0] {IDLE, BBOX, SCAN} state_t;

endpackage

// File: rtl/minmax3.sv
// Combinational signed minimum and maximum of three coordinates.
module minmax3
    import tri_pkg::*;
(
    input  coord_t a,
    input  coord_t b,
    input  coord_t c,
    output coord_t mn,
    output coord_t mx
);

    always_comb begin
        mn = a;
        if (b < mn) mn = b;
        if (c < mn) mn = c;
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;
    end

endmodule

// File: rtl/tri_bbox_scan.sv
// Accepts a triangle, forms its bounding box and streams every box point in raster order.
// Optional screen clipping of the box is enabled by defining TRI_CLIP_EN.
module tri_bbox_scan
    import tri_pkg::*;
`ifdef TRI_CLIP_EN
#(
    parameter int SCR_W = 640,
    parameter int SCR_H = 480
)
`endif
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] y1,
    input  logic signed [W-1:0] x2,
    input  logic signed [W-1:0] y2,
    input  logic signed [W-1:0] x3,
    input  logic signed [W-1:0] y3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] px,
    output logic signed [W-1:0] py,
    output logic signed [W-1:0] tx1,
    output logic signed [W-1:0] ty1,
    output logic signed [W-1:0] tx2,
    output logic signed [W-1:0] ty2,
    output logic signed [W-1:0] tx3,
    output logic signed [W-1:0] ty3,
    output logic                out_last,
    output logic                tri_done
);

    localparam coord_t ONE = coord_t'(1);

    state_t state;
    coord_t bx_min, bx_max, by_min, by_max;
    coord_t xmin, xmax, ymin, ymax;
    coord_t nx, ny;
    logic   off_screen;

    // The box is derived from the held vertices, so it stays valid for the whole scan.
    minmax3 u_mm_x (.a(tx1), .b(tx2), .c(tx3), .mn(bx_min), .mx(bx_max));
    minmax3 u_mm_y (.a(ty1), .b(ty2), .c(ty3), .mn(by_min), .mx(by_max));

`ifdef TRI_CLIP_EN
    localparam coord_t ZERO = '0;
    localparam coord_t XLIM = coord_t'(SCR_W - 1);
    localparam coord_t YLIM = coord_t'(SCR_H - 1);

    always_comb begin
        xmin       = (bx_min < ZERO) ? ZERO : bx_min;
        xmax       = (bx_max > XLIM) ? XLIM : bx_max;
        ymin       = (by_min < ZERO) ? ZERO : by_min;
        ymax       = (by_max > YLIM) ? YLIM : by_max;
        off_screen = (bx_max < ZERO) || (by_max < ZERO) || (bx_min > XLIM) || (by_min > YLIM);
    end
`else
    always_comb begin
        xmin       = bx_min;
        xmax       = bx_max;
        ymin       = by_min;
        ymax       = by_max;
        off_screen = 1'b0;
    end
`endif

    // Increments happen only below the range edge, so W bits never overflow.
    always_comb begin
        nx = px + ONE;
        ny = py;
        if (px == xmax) begin
            nx = xmin;
            ny = py + ONE;
        end
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            tri_done  <= 1'b0;
            px        <= '0;
            py        <= '0;
            tx1       <= '0;
            ty1       <= '0;
            tx2       <= '0;
            ty2       <= '0;
            tx3       <= '0;
            ty3       <= '0;
        end else begin
            tri_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tx1   <= x1;
                        ty1   <= y1;
                        tx2   <= x2;
                        ty2   <= y2;
                        tx3   <= x3;
                        ty3   <= y3;
                        state <= BBOX;
                    end
                end
                BBOX: begin
                    if (off_screen) begin
                        tri_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        px        <= xmin;
                        py        <= ymin;
                        out_last  <= (xmin == xmax) && (ymin == ymax);
                        out_valid <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            tri_done  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            px       <= nx;
                            py       <= ny;
                            out_last <= (nx == xmax) && (ny == ymax);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bbox_scan.sv
// Self-checking bench for tri_bbox_scan against a loop-based bounding-box raster model.
module tb_tri_bbox_scan;

    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready;
    logic signed [11:0] x1, y1, x2, y2, x3, y3;
    logic in_ready, out_valid, out_last, tri_done;
    logic signed [11:0] px, py, tx1, ty1, tx2, ty2, tx3, ty3;

    always #5 clk = ~clk;

    tri_bbox_scan dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .out_valid(out_valid), .out_ready(out_ready), .px(px), .py(py),
        .tx1(tx1), .ty1(ty1), .tx2(tx2), .ty2(ty2), .tx3(tx3), .ty3(ty3),
        .out_last(out_last), .tri_done(tri_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int vt[6];
    int ex[$], ey[$], gx[$], gy[$], glast[$];
    int first_lat, done_lat, done_gap, hold_err, tx_err, ir_err;
    int stall_x, stall_y, stall_len, stall_pct;

    // Reference: enumerate the (optionally clipped) box with plain integer loops.
    function automatic void build_model();
        int xl, xh, yl, yh;
        ex.delete();
        ey.delete();
        xl = vt[0]; xh = vt[0]; yl = vt[1]; yh = vt[1];
        for (int i = 1; i < 3; i++) begin
            if (vt[2*i] < xl) xl = vt[2*i];
            if (vt[2*i] > xh) xh = vt[2*i];
            if (vt[2*i+1] < yl) yl = vt[2*i+1];
            if (vt[2*i+1] > yh) yh = vt[2*i+1];
        end
`ifdef TRI_CLIP_EN
        if (xh < 0 || yh < 0 || xl > 639 || yl > 479) return;
        if (xl < 0) xl = 0;
        if (yl < 0) yl = 0;
        if (xh > 639) xh = 639;
        if (yh > 479) yh = 479;
`endif
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                ex.push_back(x);
                ey.push_back(y);
            end
    endfunction

    task automatic drive_tri();
        int cyc, stall_left, ppx, ppy, last_hs;
        bit prev_stall, plast;
        gx.delete(); gy.delete(); glast.delete();
        first_lat = -1; done_lat = -1; done_gap = -1;
        hold_err = 0; tx_err = 0; ir_err = 0;
        stall_left = stall_len;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        x1 = 12'(vt[0]); y1 = 12'(vt[1]); x2 = 12'(vt[2]);
        y2 = 12'(vt[3]); x3 = 12'(vt[4]); y3 = 12'(vt[5]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0; prev_stall = 0; last_hs = -1; ppx = 0; ppy = 0; plast = 0;
        while (cyc < 3000) begin
            if (tri_done) begin
                done_lat = cyc + 1;
                done_gap = cyc - last_hs;
                break;
            end
            if (out_valid) begin
                if (first_lat < 0) first_lat = cyc + 1;
                if (prev_stall && (int'(px) != ppx || int'(py) != ppy || out_last !== plast))
                    hold_err++;
                if (tx1 !== 12'(vt[0]) || ty1 !== 12'(vt[1]) || tx2 !== 12'(vt[2]) ||
                    ty2 !== 12'(vt[3]) || tx3 !== 12'(vt[4]) || ty3 !== 12'(vt[5]))
                    tx_err++;
                if (in_ready) ir_err++;
                out_ready = 1'b1;
                if (stall_pct > 0 && $urandom_range(99) < stall_pct) out_ready = 1'b0;
                if (stall_left > 0 && int'(px) == stall_x && int'(py) == stall_y) begin
                    out_ready = 1'b0;
                    stall_left--;
                end
                if (out_ready) begin
                    gx.push_back(int'(px));
                    gy.push_back(int'(py));
                    if (out_last) glast.push_back(gx.size() - 1);
                    last_hs = cyc;
                end
                prev_stall = !out_ready; ppx = int'(px); ppy = int'(py); plast = out_last;
            end else begin
                if (prev_stall) hold_err++;
                prev_stall = 0;
            end
            @(posedge clk); #1; cyc++;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (done_lat < 0) begin
            n_bad++;
            $display("FAIL timeout: tri_done seen=0, required=1 within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
        stall_len = 0; stall_pct = 0; stall_x = 0; stall_y = 0;
        #3;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || tri_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b done=%b, required 1 0 0 0",
                     in_ready, out_valid, out_last, tri_done);
        end
        n_cmp++;
        if (px !== 12'sd0 || py !== 12'sd0 || tx1 !== 12'sd0 || ty3 !== 12'sd0) begin
            n_bad++;
            $display("FAIL reset_data: got px=%0d py=%0d tx1=%0d ty3=%0d, required all 0",
                     px, py, tx1, ty3);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int mism;
        vt = '{0, 0, 2, 0, 0, 2};
        build_model();
        drive_tri();
        mism = 0;
        for (int i = 0; i < gx.size() && i < ex.size(); i++)
            if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
        n_cmp++;
        if (gx.size() != 9 || mism != 0) begin
            n_bad++;
            $display("FAIL basic_stream: got %0d points (%0d wrong), required 9 exact", gx.size(), mism);
        end
        n_cmp++;
        if (glast.size() != 1 || (glast.size() == 1 && glast[0] != 8)) begin
            n_bad++;
            $display("FAIL basic_last: got %0d out_last flags, required 1 at point 8", glast.size());
        end
        n_cmp++;
        if (first_lat != 2 || done_gap != 1) begin
            n_bad++;
            $display("FAIL basic_timing: got latency=%0d done_gap=%0d, required 2 1", first_lat, done_gap);
        end
        n_cmp++;
        if (tx_err != 0 || ir_err != 0) begin
            n_bad++;
            $display("FAIL basic_hold: got tx_err=%0d rdy_err=%0d, required 0 0", tx_err, ir_err);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_ready: got in_ready=%b with tri_done, required 1", in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (tri_done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_pulse: got tri_done=%b a cycle later, required 0", tri_done);
        end
    endtask

    task automatic test_stall();
        int mism;
        vt = '{0, 0, 2, 0, 0, 2};
        stall_x = 1; stall_y = 0; stall_len = 3;
        build_model();
        drive_tri();
        stall_len = 0;
        mism = 0;
        for (int i = 0; i < gx.size() && i < ex.size(); i++)
            if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
        n_cmp++;
        if (gx.size() != ex.size() || mism != 0) begin
            n_bad++;
            $display("FAIL stall_stream: got %0d points (%0d wrong), required %0d", gx.size(), mism, ex.size());
        end
        n_cmp++;
        if (hold_err != 0 || tx_err != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got hold_err=%0d tx_err=%0d, required 0 0", hold_err, tx_err);
        end
    endtask

    task automatic test_single();
        int mism;
        vt = '{5, -3, 5, -3, 5, -3};
        build_model();
        drive_tri();
        mism = 0;
        for (int i = 0; i < gx.size() && i < ex.size(); i++)
            if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
        n_cmp++;
        if (gx.size() != ex.size() || mism != 0 || glast.size() != ex.size()) begin
            n_bad++;
            $display("FAIL single_stream: got %0d points %0d lasts, required %0d of each",
                     gx.size(), glast.size(), ex.size());
        end
        n_cmp++;
        if (first_lat != (ex.size() > 0 ? 2 : -1) || done_lat != (ex.size() > 0 ? 3 : 2)) begin
            n_bad++;
            $display("FAIL single_timing: got latency=%0d done_at=%0d, required %0d %0d",
                     first_lat, done_lat, ex.size() > 0 ? 2 : -1, ex.size() > 0 ? 3 : 2);
        end
    endtask

    task automatic test_negative();
        int mism;
        vt = '{-2, -1, 1, 3, 0, -4};
        build_model();
        drive_tri();
        mism = 0;
        for (int i = 0; i < gx.size() && i < ex.size(); i++)
            if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
        n_cmp++;
        if (gx.size() != ex.size() || mism != 0) begin
            n_bad++;
            $display("FAIL neg_stream: got %0d points (%0d wrong), required %0d", gx.size(), mism, ex.size());
        end
`ifndef TRI_CLIP_EN
        n_cmp++;
        if (gx.size() != 32 || gx[0] != -2 || gy[0] != -4 || gx[gx.size()-1] != 1 || gy[gy.size()-1] != 3) begin
            n_bad++;
            $display("FAIL neg_ends: got %0d points, required 32 from (-2,-4) to (1,3)", gx.size());
        end
`endif
    endtask

    task automatic test_edge();
        int mism;
        int tri_set[2][6] = '{'{2045, 2047, 2047, 2045, 2046, 2046},
                              '{-2048, -2048, -2046, -2047, -2047, -2046}};
        stall_pct = 30;
        for (int t = 0; t < 2; t++) begin
            vt = tri_set[t];
            build_model();
            drive_tri();
            mism = 0;
            for (int i = 0; i < gx.size() && i < ex.size(); i++)
                if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
            n_cmp++;
            if (gx.size() != ex.size() || mism != 0 || hold_err != 0) begin
                n_bad++;
                $display("FAIL edge_%0d: got %0d points (%0d wrong, %0d hold), required %0d",
                         t, gx.size(), mism, hold_err, ex.size());
            end
        end
        stall_pct = 0;
    endtask

    task automatic test_reset_mid();
        int cyc, bad, mism;
        vt = '{0, 0, 2, 0, 0, 2};
        x1 = 12'sd0; y1 = 12'sd0; x2 = 12'sd2; y2 = 12'sd0; x3 = 12'sd0; y3 = 12'sd2;
        while (!in_ready) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && px == 12'sd0 && py == 12'sd1) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        n_cmp++;
        if (cyc >= 20) begin
            n_bad++;
            $display("FAIL rst_mid_reach: point 4 (0,1) not presented, got px=%0d py=%0d", px, py);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || tri_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_abort: got vld=%b rdy=%b done=%b, required 0 1 0",
                     out_valid, in_ready, tri_done);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (tri_done || out_valid) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: got %0d cycles with output activity, required 0", bad);
        end
        vt = '{-2, -1, 1, 3, 0, -4};
        build_model();
        drive_tri();
        mism = 0;
        for (int i = 0; i < gx.size() && i < ex.size(); i++)
            if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
        n_cmp++;
        if (gx.size() != ex.size() || mism != 0) begin
            n_bad++;
            $display("FAIL rst_mid_next: got %0d points (%0d wrong), required %0d", gx.size(), mism, ex.size());
        end
    endtask

    task automatic test_random();
        int mism, lerr;
        stall_pct = 25;
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 6; k++) vt[k] = int'($urandom_range(16)) - 8;
            build_model();
            drive_tri();
            mism = 0;
            for (int i = 0; i < gx.size() && i < ex.size(); i++)
                if (gx[i] != ex[i] || gy[i] != ey[i]) mism++;
            lerr = (ex.size() == 0) ? int'(glast.size()) :
                   ((glast.size() == 1 && glast[0] == ex.size() - 1) ? 0 : 1);
            n_cmp++;
            if (gx.size() != ex.size() || mism != 0 || lerr != 0 || hold_err != 0 || tx_err != 0) begin
                n_bad++;
                $display("FAIL rand_%0d: got %0d pts wrong=%0d lasterr=%0d hold=%0d tx=%0d, required %0d pts",
                         t, gx.size(), mism, lerr, hold_err, tx_err, ex.size());
            end
            n_cmp++;
            if (ex.size() > 0 && (first_lat != 2 || done_gap != 1)) begin
                n_bad++;
                $display("FAIL rand_timing_%0d: got latency=%0d done_gap=%0d, required 2 1",
                         t, first_lat, done_gap);
            end
        end
        stall_pct = 0;
    endtask

`ifdef TRI_CLIP_EN
    task automatic test_clip();
        vt = '{-5, -5, -1, -1, -3, -1};
        drive_tri();
        n_cmp++;
        if (gx.size() != 0 || done_lat != 2) begin
            n_bad++;
            $display("FAIL clip_off: got %0d points done_at=%0d, required 0 2", gx.size(), done_lat);
        end
        vt = '{630, 470, 700, 470, 630, 500};
        drive_tri();
        n_cmp++;
        if (gx.size() != 100 || gx[0] != 630 || gy[0] != 470 || gx[99] != 639 || gy[99] != 479) begin
            n_bad++;
            $display("FAIL clip_edge: got %0d points, required 100 from (630,470) to (639,479)", gx.size());
        end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_single();
        test_negative();
        test_edge();
        test_reset_mid();
        test_random();
`ifdef TRI_CLIP_EN
        test_clip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
